// File: rtl/mux_scan_controller_if.sv
// Handshake and mux-facing signals of the scan sequencer.
// The controller takes the master side; the mux and frame consumer take the slave side.
interface mux_scan_controller_if #(
   parameter int N_POS = 35
);
   logic             start;
   logic             continuous;
   logic             mux_out;
   logic             frame_ack;
   logic [5:0]       mux_sel;
   logic [N_POS-1:0] frame;
   logic             frame_valid;
   logic             busy;

   modport master (
      input  start, continuous, mux_out, frame_ack,
      output mux_sel, frame, frame_valid, busy
   );

   modport slave (
      output start, continuous, mux_out, frame_ack,
      input  mux_sel, frame, frame_valid, busy
   );
endinterface

// File: rtl/mux_scan_controller.sv
// Steps the 36:1 mux select through every live code at a fixed dwell.
// Each sampled bit lands in a shadow frame, which is published with a valid/ack handshake.
module mux_scan_controller #(
   parameter int TICK_DIV = 4,
   parameter int N_POS    = 35,
   parameter int PARK_SEL = 63
) (
   input  logic                  clk,
   input  logic                  reset,
   mux_scan_controller_if.master bus
);

   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

   localparam logic [7:0] LAST_CNT = 8'(TICK_DIV - 1);
   localparam logic [5:0] LAST_SEL = 6'(N_POS - 1);
   localparam logic [5:0] PARK     = 6'(PARK_SEL);

   state_t           state_q, state_d;
   logic [5:0]       muxSel_q, muxSel_d;
   logic [7:0]       dwellCnt_q, dwellCnt_d;
   logic [N_POS-1:0] shadow_q, shadow_d;
   logic [N_POS-1:0] frame_q, frame_d;
   logic             frameValid_q, frameValid_d;
   logic             busy_q, busy_d;
   logic [5:0]       shadowIdx;
   logic [N_POS-1:0] sampled;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         muxSel_q     <= PARK;
         dwellCnt_q   <= '0;
         shadow_q     <= '0;
         frame_q      <= '0;
         frameValid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         muxSel_q     <= muxSel_d;
         dwellCnt_q   <= dwellCnt_d;
         shadow_q     <= shadow_d;
         frame_q      <= frame_d;
         frameValid_q <= frameValid_d;
         busy_q       <= busy_d;
      end
   end

   // Select s routes A[N_POS-s], so its sample belongs in shadow bit N_POS-1-s.
   always_comb begin
      shadowIdx          = LAST_SEL - muxSel_q;
      sampled            = shadow_q;
      sampled[shadowIdx] = bus.mux_out;
   end

   always_comb begin
      state_d      = state_q;
      muxSel_d     = muxSel_q;
      dwellCnt_d   = dwellCnt_q;
      shadow_d     = shadow_q;
      frame_d      = frame_q;
      frameValid_d = frameValid_q;

      unique case (state_q)
         IDLE: begin
            muxSel_d = PARK;
            if (bus.start) begin
               state_d    = SCAN;
               muxSel_d   = '0;
               dwellCnt_d = '0;
            end
         end
         SCAN: begin
            if (dwellCnt_q == LAST_CNT) begin
               dwellCnt_d = '0;
               shadow_d   = sampled;
               if (muxSel_q < LAST_SEL) begin
                  muxSel_d = muxSel_q + 6'd1;
               end else begin
                  frame_d      = sampled;
                  frameValid_d = 1'b1;
                  muxSel_d     = PARK;
                  state_d      = HOLD;
               end
            end else begin
               dwellCnt_d = dwellCnt_q + 8'd1;
            end
         end
         HOLD: begin
            // The frame is never overwritten while it waits for an ack.
            muxSel_d = PARK;
            if (bus.frame_ack) begin
               frameValid_d = 1'b0;
               if (bus.continuous) begin
                  state_d    = SCAN;
                  muxSel_d   = '0;
                  dwellCnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            muxSel_d = PARK;
         end
      endcase

      busy_d = (state_d == SCAN);
   end

   assign bus.mux_sel     = muxSel_q;
   assign bus.frame       = frame_q;
   assign bus.frame_valid = frameValid_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller: a behavioural 36:1 mux feeds two DUTs (dwell 4 and dwell 1).
// Expected frames are queued when a scan starts and popped when frame_valid rises.
module tb_mux_scan_controller;

   logic clk;
   logic reset;

   mux_scan_controller_if #(.N_POS(35)) scanBus ();
   mux_scan_controller_if #(.N_POS(35)) scanBus1 ();

   logic [34:0] aBits;
   logic [34:0] aBits1;
   logic [34:0] expQ[$];

   int compared;
   int mismatched;

   mux_scan_controller #(.TICK_DIV(4), .N_POS(35), .PARK_SEL(63)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (scanBus)
   );

   mux_scan_controller #(.TICK_DIV(1), .N_POS(35), .PARK_SEL(63)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (scanBus1)
   );

   // aBits[k] models mux input A[k+1]; select s routes A[35-s], and codes 35 and up read 0.
   assign scanBus.mux_out  = (scanBus.mux_sel < 6'd35)  ? aBits[6'd34 - scanBus.mux_sel]   : 1'b0;
   assign scanBus1.mux_out = (scanBus1.mux_sel < 6'd35) ? aBits1[6'd34 - scanBus1.mux_sel] : 1'b0;

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitFrame(output int cycles);
      cycles = 0;
      while (scanBus.frame_valid !== 1'b1 && cycles < 400) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      logic [34:0] exp;
      repeat (3) tick();
      compared++;
      if (scanBus.mux_sel !== 6'd63 || scanBus.frame_valid !== 1'b0 || scanBus.busy !== 1'b0 || scanBus.frame !== 35'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_state: sel=%0d valid=%b busy=%b frame=%h required sel=63 valid=0 busy=0 frame=0",
                  scanBus.mux_sel, scanBus.frame_valid, scanBus.busy, scanBus.frame);
      end
      reset = 1'b0;
      repeat (5) tick();
      exp = 35'h0;
      compared++;
      if (scanBus.mux_sel !== 6'd63 || scanBus.busy !== 1'b0 || scanBus1.mux_sel !== 6'd63 || scanBus1.frame !== exp) begin
         mismatched++;
         $display("[TB] FAIL idle_after_reset: sel=%0d busy=%b sel1=%0d frame1=%h required sel=63 busy=0 frame1=0",
                  scanBus.mux_sel, scanBus.busy, scanBus1.mux_sel, scanBus1.frame);
      end
   endtask

   task automatic test_single_shot();
      int cycles;
      logic [5:0]  expSel;
      logic [34:0] exp;
      scanBus.continuous = 1'b0;
      aBits = 35'h5_A5A5_A5A5;
      expQ.push_back(aBits);
      scanBus.start = 1'b1;
      tick();
      scanBus.start = 1'b0;
      cycles = 0;
      while (scanBus.frame_valid !== 1'b1 && cycles < 400) begin
         expSel = 6'(cycles / 4);
         compared++;
         if (scanBus.mux_sel !== expSel || scanBus.busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL select_sequence: cycle %0d sel=%0d busy=%b required sel=%0d busy=1",
                     cycles, scanBus.mux_sel, scanBus.busy, expSel);
         end
         tick();
         cycles++;
      end
      compared++;
      if (cycles !== 140) begin
         mismatched++;
         $display("[TB] FAIL single_latency: got %0d cycles required 140", cycles);
      end
      exp = (expQ.size() > 0) ? expQ.pop_front() : 35'hX;
      compared++;
      if (scanBus.frame !== exp || scanBus.mux_sel !== 6'd63 || scanBus.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL single_frame: frame=%h sel=%0d busy=%b required frame=%h sel=63 busy=0",
                  scanBus.frame, scanBus.mux_sel, scanBus.busy, exp);
      end
      scanBus.frame_ack = 1'b1;
      tick();
      scanBus.frame_ack = 1'b0;
      repeat (3) tick();
      compared++;
      if (scanBus.frame_valid !== 1'b0 || scanBus.mux_sel !== 6'd63 || scanBus.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL single_ack_idle: valid=%b sel=%0d busy=%b required valid=0 sel=63 busy=0",
                  scanBus.frame_valid, scanBus.mux_sel, scanBus.busy);
      end
   endtask

   task automatic test_backpressure();
      int cycles;
      int badCycles;
      logic [34:0] exp;
      aBits = 35'h2_3456_789A;
      expQ.push_back(aBits);
      scanBus.start = 1'b1;
      tick();
      scanBus.start = 1'b0;
      waitFrame(cycles);
      compared++;
      if (cycles !== 140) begin
         mismatched++;
         $display("[TB] FAIL backpressure_latency: got %0d cycles required 140", cycles);
      end
      exp = (expQ.size() > 0) ? expQ.pop_front() : 35'hX;
      badCycles = 0;
      for (int i = 0; i < 500; i++) begin
         scanBus.start = 1'($urandom_range(0, 1));
         aBits = {3'($urandom), 32'($urandom)};
         tick();
         compared++;
         if (scanBus.frame_valid !== 1'b1 || scanBus.frame !== exp || scanBus.mux_sel !== 6'd63 || scanBus.busy !== 1'b0) begin
            mismatched++;
            badCycles++;
            if (badCycles <= 5)
               $display("[TB] FAIL backpressure_hold: cycle %0d valid=%b frame=%h sel=%0d busy=%b required valid=1 frame=%h sel=63 busy=0",
                        i, scanBus.frame_valid, scanBus.frame, scanBus.mux_sel, scanBus.busy, exp);
         end
      end
      scanBus.start = 1'b0;
      scanBus.frame_ack = 1'b1;
      tick();
      scanBus.frame_ack = 1'b0;
      repeat (3) tick();
      compared++;
      if (scanBus.frame_valid !== 1'b0 || scanBus.busy !== 1'b0 || scanBus.mux_sel !== 6'd63) begin
         mismatched++;
         $display("[TB] FAIL backpressure_release: valid=%b busy=%b sel=%0d required valid=0 busy=0 sel=63",
                  scanBus.frame_valid, scanBus.busy, scanBus.mux_sel);
      end
   endtask

   task automatic test_continuous();
      int cycles;
      logic [34:0] exp;
      logic [34:0] oldFrame;
      scanBus.continuous = 1'b1;
      aBits = 35'h5_A5A5_A5A5;
      expQ.push_back(aBits);
      scanBus.start = 1'b1;
      tick();
      scanBus.start = 1'b0;
      waitFrame(cycles);
      exp = (expQ.size() > 0) ? expQ.pop_front() : 35'hX;
      compared++;
      if (cycles !== 140 || scanBus.frame !== exp) begin
         mismatched++;
         $display("[TB] FAIL continuous_first: cycles=%0d frame=%h required cycles=140 frame=%h", cycles, scanBus.frame, exp);
      end
      oldFrame = exp;
      aBits = 35'h7_FFFF_FFFF;
      expQ.push_back(aBits);
      scanBus.frame_ack = 1'b1;
      tick();
      scanBus.frame_ack = 1'b0;
      compared++;
      if (scanBus.frame_valid !== 1'b0 || scanBus.busy !== 1'b1 || scanBus.mux_sel !== 6'd0) begin
         mismatched++;
         $display("[TB] FAIL continuous_rescan: valid=%b busy=%b sel=%0d required valid=0 busy=1 sel=0",
                  scanBus.frame_valid, scanBus.busy, scanBus.mux_sel);
      end
      cycles = 0;
      while (scanBus.frame_valid !== 1'b1 && cycles < 400) begin
         compared++;
         if (scanBus.frame !== oldFrame) begin
            mismatched++;
            $display("[TB] FAIL continuous_old_held: cycle %0d frame=%h required %h", cycles, scanBus.frame, oldFrame);
         end
         tick();
         cycles++;
      end
      exp = (expQ.size() > 0) ? expQ.pop_front() : 35'hX;
      compared++;
      if (cycles !== 140 || scanBus.frame !== exp) begin
         mismatched++;
         $display("[TB] FAIL continuous_second: cycles=%0d frame=%h required cycles=140 frame=%h", cycles, scanBus.frame, exp);
      end
      scanBus.continuous = 1'b0;
      scanBus.frame_ack = 1'b1;
      tick();
      scanBus.frame_ack = 1'b0;
      repeat (2) tick();
      compared++;
      if (scanBus.busy !== 1'b0 || scanBus.mux_sel !== 6'd63 || scanBus.frame_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL continuous_stop: busy=%b sel=%0d valid=%b required busy=0 sel=63 valid=0",
                  scanBus.busy, scanBus.mux_sel, scanBus.frame_valid);
      end
   endtask

   task automatic test_reset_mid_scan();
      int badCycles;
      aBits = 35'h1_2345_6789;
      expQ.push_back(aBits);
      scanBus.start = 1'b1;
      tick();
      scanBus.start = 1'b0;
      repeat (49) tick();
      reset = 1'b1;
      #1;
      compared++;
      if (scanBus.mux_sel !== 6'd63 || scanBus.frame_valid !== 1'b0 || scanBus.busy !== 1'b0 || scanBus.frame !== 35'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_scan: sel=%0d valid=%b busy=%b frame=%h required sel=63 valid=0 busy=0 frame=0",
                  scanBus.mux_sel, scanBus.frame_valid, scanBus.busy, scanBus.frame);
      end
      expQ.delete();
      repeat (2) tick();
      reset = 1'b0;
      badCycles = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         compared++;
         if (scanBus.mux_sel !== 6'd63 || scanBus.frame_valid !== 1'b0 || scanBus.busy !== 1'b0 || scanBus.frame !== 35'h0) begin
            mismatched++;
            badCycles++;
            if (badCycles <= 5)
               $display("[TB] FAIL reset_quiet: cycle %0d sel=%0d valid=%b busy=%b frame=%h required sel=63 valid=0 busy=0 frame=0",
                        i, scanBus.mux_sel, scanBus.frame_valid, scanBus.busy, scanBus.frame);
         end
      end
   endtask

   task automatic test_tick_div1();
      int cycles;
      logic [34:0] exp;
      aBits1 = 35'h0_0000_0001;
      expQ.push_back(aBits1);
      scanBus1.start = 1'b1;
      tick();
      scanBus1.start = 1'b0;
      cycles = 0;
      while (scanBus1.frame_valid !== 1'b1 && cycles < 200) begin
         compared++;
         if (scanBus1.mux_sel !== 6'(cycles)) begin
            mismatched++;
            $display("[TB] FAIL div1_sequence: cycle %0d sel=%0d required %0d", cycles, scanBus1.mux_sel, cycles);
         end
         tick();
         cycles++;
      end
      exp = (expQ.size() > 0) ? expQ.pop_front() : 35'hX;
      compared++;
      if (cycles !== 35 || scanBus1.frame !== exp || scanBus1.mux_sel !== 6'd63) begin
         mismatched++;
         $display("[TB] FAIL div1_frame: cycles=%0d frame=%h sel=%0d required cycles=35 frame=%h sel=63",
                  cycles, scanBus1.frame, scanBus1.mux_sel, exp);
      end
      scanBus1.frame_ack = 1'b1;
      tick();
      scanBus1.frame_ack = 1'b0;
      compared++;
      if (scanBus1.frame_valid !== 1'b0 || scanBus1.busy !== 1'b0 || scanBus1.frame !== exp) begin
         mismatched++;
         $display("[TB] FAIL div1_ack: valid=%b busy=%b frame=%h required valid=0 busy=0 frame=%h",
                  scanBus1.frame_valid, scanBus1.busy, scanBus1.frame, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      reset = 1'b1;
      compared = 0;
      mismatched = 0;
      aBits = '0;
      aBits1 = '0;
      scanBus.start = 1'b0;
      scanBus.continuous = 1'b0;
      scanBus.frame_ack = 1'b0;
      scanBus1.start = 1'b0;
      scanBus1.continuous = 1'b0;
      scanBus1.frame_ack = 1'b0;

      test_reset();
      test_single_shot();
      test_backpressure();
      test_continuous();
      test_reset_mid_scan();
      test_tick_div1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
